register_file: RTL and testbench

- Architectural integer register file for the RISC-V core: 32 registers of 32 bits each.
- Two combinational read ports (rs1/rs2) and one synchronous write port (rd).
- Register x0 is hardwired to zero.
- Sits between instruction decode (A1/A2/A3 from instruction fields) and the ALU/writeback path.

---
 rtl/register_file.sv | 55 +++++
 tb/tb_register_file.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural integer register file: 2**ADDR_WIDTH x DATA_WIDTH.
// It has two combinational read ports and one synchronous write port.
// x0 always reads as zero. BYPASS=1 forwards a same-cycle write to the read ports.
module register_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    input  logic                  WE3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  fwd_ok;

    // Storage: async clear, write on rising edge, writes to x0 dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (WE3 && (A3 != '0)) begin
            regs[A3] <= WD3;
        end
    end

    // Forwarding is only legal for a real, non-x0 write outside reset
    assign fwd_ok = BYPASS && rst && WE3 && (A3 != '0);

    // Combinational read ports with optional write-through
    always_comb begin
        RD1 = regs[A1];
        RD2 = regs[A2];
        if (fwd_ok && (A1 == A3)) begin
            RD1 = WD3;
        end
        if (fwd_ok && (A2 == A3)) begin
            RD2 = WD3;
        end
        if (A1 == '0) begin
            RD1 = '0;
        end
        if (A2 == '0) begin
            RD2 = '0;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a BYPASS=0 and a BYPASS=1 instance share the same stimulus.
// Both are checked against an array model and against literal expectations.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic        WE3;
    logic [31:0] rd1_b0, rd2_b0, rd1_b1, rd2_b1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [31:0] mdl [32];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .WE3(WE3), .RD1(rd1_b0), .RD2(rd2_b0)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .A1(A1), .A2(A2), .A3(A3),
        .WD3(WD3), .WE3(WE3), .RD1(rd1_b1), .RD2(rd2_b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected read value from the architectural rules
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst === 1'b1 && WE3 === 1'b1 && A3 != 5'd0 && A3 == a) return WD3;
        return mdl[a];
    endfunction

    // Model: clear immediately on reset, commit writes at the edge
    always @(negedge rst) begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (rst === 1'b1 && WE3 === 1'b1 && A3 != 5'd0) mdl[A3] = WD3;
    end

    // Per-cycle comparison mid-cycle, away from the write edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_rd1_b0", rd1_b0, exp_rd(A1, 1'b0));
            check("cyc_rd2_b0", rd2_b0, exp_rd(A2, 1'b0));
            check("cyc_rd1_b1", rd1_b1, exp_rd(A1, 1'b1));
            check("cyc_rd2_b1", rd2_b1, exp_rd(A2, 1'b1));
        end
    end

    // Hold inputs across exactly one rising edge, return just after it
    task automatic step(input logic we, input logic [4:0] a3v, input logic [31:0] wd,
                        input logic [4:0] a1v, input logic [4:0] a2v);
        WE3 = we; A3 = a3v; WD3 = wd; A1 = a1v; A2 = a2v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        rst = 1'b1; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
        #1;
        rst = 1'b0;
        #1;
        chk_en = 1'b1;

        // Reset held two edges with a write attempt that must be blocked
        step(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd0, 5'd1);
        check("rst_rd1", rd1_b0, 32'h0);
        check("rst_rd2", rd2_b0, 32'h0);
        step(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd0, 5'd1);
        check("rst_rd2_b1", rd2_b1, 32'h0);
        rst = 1'b1;
        WE3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(31 - i);
            #1;
            check("post_rst_rd1", rd1_b0, 32'h0);
            check("post_rst_rd2", rd2_b1, 32'h0);
        end
        @(posedge clk); #1;

        // Basic write then read
        step(1'b1, 5'd2, 32'h1234_5678, 5'd1, 5'd3);
        WE3 = 1'b0; A1 = 5'd1; A2 = 5'd2;
        #2;
        check("basic_rd1", rd1_b0, 32'h0000_0000);
        check("basic_rd2", rd2_b0, 32'h1234_5678);

        // Write disabled, then write to x0
        step(1'b0, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        A1 = 5'd5; #2;
        check("we0_rd1", rd1_b0, 32'h0);
        WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; A1 = 5'd0; #2;
        check("x0_byp_rd1", rd1_b1, 32'h0);
        @(posedge clk); #1;
        WE3 = 1'b0; #2;
        check("x0_rd1", rd1_b0, 32'h0);
        check("x0_rd1_b1", rd1_b1, 32'h0);

        // Full sweep: distinct value in every register, read on both ports
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 5'd0, 5'd0);
        WE3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i); A2 = 5'(i);
            #1;
            v = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
            check("sweep_rd1", rd1_b0, v);
            check("sweep_rd2", rd2_b0, v);
        end
        @(posedge clk); #1;

        // Read/write collision with and without forwarding
        step(1'b1, 5'd7, 32'h1111_1111, 5'd0, 5'd0);
        WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h2222_2222; A1 = 5'd7; A2 = 5'd7;
        #2;
        check("coll_pre_b0", rd1_b0, 32'h1111_1111);
        check("coll_pre_b1", rd1_b1, 32'h2222_2222);
        check("coll_pre_b1_rd2", rd2_b1, 32'h2222_2222);
        @(posedge clk); #1;
        WE3 = 1'b0; #1;
        check("coll_post_b0", rd1_b0, 32'h2222_2222);
        check("coll_post_b1", rd2_b1, 32'h2222_2222);

        // Asynchronous reset between edges, write attempt during reset
        step(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3);
        WE3 = 1'b0; #1;
        check("async_pre", rd1_b0, 32'hCAFE_F00D);
        rst = 1'b0; #1;
        check("async_rd1_b0", rd1_b0, 32'h0);
        check("async_rd1_b1", rd1_b1, 32'h0);
        WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        check("async_wr_blk", rd1_b0, 32'h0);
        rst = 1'b1; WE3 = 1'b0; #1;
        check("async_after", rd2_b0, 32'h0);
        @(posedge clk); #1;

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 600; n++) begin
            logic [4:0] ra3;
            ra3 = 5'($urandom_range(0, 31));
            rst = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
            step(1'($urandom_range(0, 1)), ra3, $urandom(),
                 ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? ra3 : 5'($urandom_range(0, 31)));
        end
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
